// File: rtl/dmem_pkg.sv
// dmem_pkg: shared FSM state encoding and default widths for dmem_arbiter and its bench
package dmem_pkg;
  localparam int DW_DEF    = 16;
  localparam int DEPTH_DEF = 1024;
  localparam int CNT_W     = 16;
  typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: 2-input round-robin arbiter (in: clk, rst, req0/req1, adv; out: any, gnt = winning port id)
module rr_arb2 (
  input  logic clk,
  input  logic rst,
  input  logic req0,
  input  logic req1,
  input  logic adv,
  output logic any,
  output logic gnt
);
  logic ptr_q, ptr_d;
  always_comb begin
    any   = req0 | req1;
    gnt   = (req0 & req1) ? ptr_q : req1;
    ptr_d = (adv & any) ? ~gnt : ptr_q;
  end
  always_ff @(posedge clk) ptr_q <= rst ? 1'b0 : ptr_d;
endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin data-memory arbiter (in: clk, rst, req/we/addr/wdata per port, mem_rdata; out: done/err per port, rdata, mem_r/mem_w/mem_addr/mem_wdata, acc_cnt)
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [DW-1:0]     addr0,
  input  logic [DW-1:0]     addr1,
  input  logic [DW-1:0]     wdata0,
  input  logic [DW-1:0]     wdata1,
  output logic              done0,
  output logic              done1,
  output logic              err0,
  output logic              err1,
  output logic [DW-1:0]     rdata,
  output logic              mem_r,
  output logic              mem_w,
  output logic [DW-1:0]     mem_addr,
  output logic [DW-1:0]     mem_wdata,
  input  logic [DW-1:0]     mem_rdata,
  output logic [CNT_W-1:0]  acc_cnt
);
  state_t state_q, state_d;
  logic id_q, id_d, we_q, we_d;
  logic mem_r_q, mem_r_d, mem_w_q, mem_w_d;
  logic done0_q, done0_d, done1_q, done1_d, err0_q, err0_d, err1_q, err1_d;
  logic [DW-1:0] addr_q, addr_d, wdata_q, wdata_d, rdata_q, rdata_d, sel_addr;
  logic [CNT_W-1:0] acc_cnt_q, acc_cnt_d;
  logic any, gnt, sel_in, cur_in;
  rr_arb2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req0 (req0),
    .req1 (req1),
    .adv  (state_q == IDLE),
    .any  (any),
    .gnt  (gnt)
  );
  // Range check on the incoming winner sets up the enables registered into ACCESS
  assign sel_addr = gnt ? addr1 : addr0;
  assign sel_in   = {1'b0, sel_addr} < (DW+1)'(DEPTH);
  assign cur_in   = {1'b0, addr_q} < (DW+1)'(DEPTH);
  always_comb begin
    state_d   = state_q;
    id_d      = id_q;
    we_d      = we_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    acc_cnt_d = acc_cnt_q;
    mem_r_d   = 1'b0;
    mem_w_d   = 1'b0;
    done0_d   = 1'b0;
    done1_d   = 1'b0;
    err0_d    = 1'b0;
    err1_d    = 1'b0;
    case (state_q)
      IDLE: if (any) begin
        state_d = ACCESS;
        id_d    = gnt;
        we_d    = gnt ? we1 : we0;
        addr_d  = sel_addr;
        wdata_d = gnt ? wdata1 : wdata0;
        mem_r_d = sel_in & ~we_d;
        mem_w_d = sel_in & we_d;
      end
      ACCESS: begin
        state_d   = DONE;
        rdata_d   = (cur_in & ~we_q) ? mem_rdata : '0;
        done0_d   = ~id_q;
        done1_d   = id_q;
        err0_d    = ~id_q & ~cur_in;
        err1_d    = id_q & ~cur_in;
        acc_cnt_d = acc_cnt_q + CNT_W'(cur_in);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      id_q      <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      rdata_q   <= '0;
      acc_cnt_q <= '0;
      mem_r_q   <= 1'b0;
      mem_w_q   <= 1'b0;
      done0_q   <= 1'b0;
      done1_q   <= 1'b0;
      err0_q    <= 1'b0;
      err1_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      id_q      <= id_d;
      we_q      <= we_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      acc_cnt_q <= acc_cnt_d;
      mem_r_q   <= mem_r_d;
      mem_w_q   <= mem_w_d;
      done0_q   <= done0_d;
      done1_q   <= done1_d;
      err0_q    <= err0_d;
      err1_q    <= err1_d;
    end
  end
  assign done0     = done0_q;
  assign done1     = done1_q;
  assign err0      = err0_q;
  assign err1      = err1_q;
  assign rdata     = rdata_q;
  assign mem_r     = mem_r_q;
  assign mem_w     = mem_w_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign acc_cnt   = acc_cnt_q;
endmodule
